punc_control_hs: RTL and testbench

PUNC_CONTROL_HS -- requirements
Module: punc_control_hs

---
 rtl/punc_pkg.sv | 51 +++++
 rtl/punc_mem_timer.sv | 22 ++
 rtl/punc_control_hs.sv | 162 ++++++++++++++++
 tb/tb_punc_control_hs.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/punc_pkg.sv
// punc_pkg: opcodes, FSM state encoding and datapath select encodings shared by the PUNC control unit
package punc_pkg;
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_MEM_I,
        S_HALT,
        S_FAULT
    } state_t;
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_HLT = 4'b1101;
    localparam logic [3:0] OP_LEA = 4'b1110;
    localparam logic [1:0] ADDR_PC   = 2'd0;
    localparam logic [1:0] ADDR_ALU  = 2'd1;
    localparam logic [1:0] ADDR_TEMP = 2'd2;
    localparam logic RFW_DR = 1'b0;
    localparam logic RFW_R7 = 1'b1;
    localparam logic [1:0] RFD_ALU = 2'd0;
    localparam logic [1:0] RFD_MEM = 2'd1;
    localparam logic [1:0] RFD_PC  = 2'd2;
    localparam logic [1:0] R0_SR1  = 2'd0;
    localparam logic [1:0] R0_BASE = 2'd1;
    localparam logic [1:0] R0_SR   = 2'd2;
    localparam logic IN0_RF0 = 1'b0;
    localparam logic IN0_PC  = 1'b1;
    localparam logic [2:0] IN1_RF1     = 3'd0;
    localparam logic [2:0] IN1_IMM5    = 3'd1;
    localparam logic [2:0] IN1_OFF6    = 3'd2;
    localparam logic [2:0] IN1_PCOFF9  = 3'd3;
    localparam logic [2:0] IN1_PCOFF11 = 3'd4;
    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_AND  = 2'd1;
    localparam logic [1:0] ALU_NOT  = 2'd2;
    localparam logic [1:0] ALU_PASS = 2'd3;
    function automatic logic br_taken(input logic [2:0] nzp, input logic [2:0] cond);
        return |(nzp & cond);
    endfunction
endpackage

// File: rtl/punc_mem_timer.sv
// punc_mem_timer: counts stalled memory-request cycles and flags when the wait limit is hit
module punc_mem_timer #(
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expired
);
    logic [TMO_W-1:0] cnt;
    // Count consecutive cycles the request has gone unanswered
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (run)
            cnt <= cnt + TMO_W'(1);
    assign expired = run && cnt == TMO_W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/punc_control_hs.sv
// punc_control_hs: PUNC multicycle control FSM with memory handshake; PUNC_CTRL_TIMEOUT_EN adds an ack-wait timeout to FAULT
module punc_control_hs
    import punc_pkg::*;
#(
    parameter int IR_W        = 16,
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IR_W-1:0] ir,
    input  logic [2:0]      cond,
    input  logic            mem_ack,
    output logic            mem_req,
    output logic            mem_we,
    output logic [1:0]      mem_addr_sel,
    output logic            ir_ld,
    output logic            pc_ld,
    output logic            pc_inc,
    output logic            temp_ld,
    output logic            rf_w_en,
    output logic            status_w_en,
    output logic            rf_w_addr_sel,
    output logic [1:0]      rf_w_data_sel,
    output logic [1:0]      rf_r0_sel,
    output logic            alu_in0_sel,
    output logic [2:0]      alu_in1_sel,
    output logic [1:0]      alu_sel,
    output logic            halted,
    output logic            fault
);
    state_t state;
    logic [3:0] op;
    logic is_ld, is_st, is_ind, base_rel, expired, unused_ir;
    assign op        = ir[IR_W-1 -: 4];
    assign is_ld     = op == OP_LD || op == OP_LDR;
    assign is_st     = op == OP_ST || op == OP_STR;
    assign is_ind    = op == OP_LDI || op == OP_STI;
    assign base_rel  = op == OP_LDR || op == OP_STR;
    assign unused_ir = ^ir;

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 2**TMO_W - 1) begin : g_bad_cfg
        $error("MEM_TIMEOUT must lie in 1..2**TMO_W-1");
    end

`ifdef PUNC_CTRL_TIMEOUT_EN
    punc_mem_timer #(.TMO_W(TMO_W), .MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (mem_req && !mem_ack),
        .clr    (!mem_req || mem_ack),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    // Sequence fetch/decode/execute/memory phases; HALT and FAULT are absorbing
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= S_FETCH;
        else if (expired)
            state <= S_FAULT;
        else
            case (state)
                S_FETCH:  if (mem_ack) state <= S_DECODE;
                S_DECODE: state <= S_EXEC;
                S_EXEC:   state <= (is_ld || is_st || is_ind) ? S_MEM : op == OP_HLT ? S_HALT : S_FETCH;
                S_MEM:    if (mem_ack) state <= is_ind ? S_MEM_I : S_FETCH;
                S_MEM_I:  if (mem_ack) state <= S_FETCH;
                default:  state <= state;
            endcase

    // Decode datapath controls from state and instruction; everything is held low during reset
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = ADDR_PC;
        ir_ld         = 1'b0;
        pc_ld         = 1'b0;
        pc_inc        = 1'b0;
        temp_ld       = 1'b0;
        rf_w_en       = 1'b0;
        status_w_en   = 1'b0;
        rf_w_addr_sel = RFW_DR;
        rf_w_data_sel = RFD_ALU;
        rf_r0_sel     = R0_SR1;
        alu_in0_sel   = IN0_RF0;
        alu_in1_sel   = IN1_RF1;
        alu_sel       = ALU_ADD;
        halted        = 1'b0;
        fault         = 1'b0;
        if (!rst)
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_ld   = mem_ack;
                end
                S_DECODE: pc_inc = 1'b1;
                S_EXEC:
                    case (op)
                        OP_ADD, OP_AND, OP_NOT: begin
                            rf_w_en     = 1'b1;
                            status_w_en = 1'b1;
                            alu_in1_sel = ir[5] ? IN1_IMM5 : IN1_RF1;
                            alu_sel     = op == OP_ADD ? ALU_ADD : op == OP_AND ? ALU_AND : ALU_NOT;
                        end
                        OP_BR: begin
                            pc_ld       = br_taken(ir[11:9], cond);
                            alu_in0_sel = IN0_PC;
                            alu_in1_sel = IN1_PCOFF9;
                        end
                        OP_JMP: begin
                            pc_ld     = 1'b1;
                            rf_r0_sel = R0_BASE;
                            alu_sel   = ALU_PASS;
                        end
                        OP_JSR: begin
                            pc_ld         = 1'b1;
                            rf_w_en       = 1'b1;
                            rf_w_addr_sel = RFW_R7;
                            rf_w_data_sel = RFD_PC;
                            rf_r0_sel     = ir[11] ? R0_SR1 : R0_BASE;
                            alu_in0_sel   = ir[11] ? IN0_PC : IN0_RF0;
                            alu_in1_sel   = ir[11] ? IN1_PCOFF11 : IN1_RF1;
                            alu_sel       = ir[11] ? ALU_ADD : ALU_PASS;
                        end
                        OP_LEA: begin
                            rf_w_en     = 1'b1;
                            status_w_en = 1'b1;
                            alu_in0_sel = IN0_PC;
                            alu_in1_sel = IN1_PCOFF9;
                        end
                        default: ;
                    endcase
                S_MEM: begin
                    mem_req       = 1'b1;
                    mem_addr_sel  = ADDR_ALU;
                    mem_we        = is_st;
                    rf_r0_sel     = is_st ? R0_SR : base_rel ? R0_BASE : R0_SR1;
                    alu_in0_sel   = base_rel ? IN0_RF0 : IN0_PC;
                    alu_in1_sel   = base_rel ? IN1_OFF6 : IN1_PCOFF9;
                    rf_w_data_sel = is_ld ? RFD_MEM : RFD_ALU;
                    rf_w_en       = is_ld && mem_ack;
                    status_w_en   = is_ld && mem_ack;
                    temp_ld       = is_ind && mem_ack;
                end
                S_MEM_I: begin
                    mem_req       = 1'b1;
                    mem_addr_sel  = ADDR_TEMP;
                    mem_we        = op == OP_STI;
                    rf_r0_sel     = op == OP_STI ? R0_SR : R0_SR1;
                    rf_w_data_sel = op == OP_LDI ? RFD_MEM : RFD_ALU;
                    rf_w_en       = op == OP_LDI && mem_ack;
                    status_w_en   = op == OP_LDI && mem_ack;
                end
                S_HALT:  halted = 1'b1;
                S_FAULT: fault  = 1'b1;
                default: ;
            endcase
    end
endmodule

// File: tb/tb_punc_control_hs.sv
// tb_punc_control_hs: directed scoreboard bench for punc_control_hs; define PUNC_CTRL_TIMEOUT_EN to also check the timeout path
module tb_punc_control_hs;
`ifdef PUNC_CTRL_TIMEOUT_EN
    localparam int MT = 4;
    localparam int LD_WAIT = 3;
`else
    localparam int MT = 200;
    localparam int LD_WAIT = 5;
`endif
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic [1:0] addr;
        logic       ir_ld;
        logic       pc_ld;
        logic       pc_inc;
        logic       temp_ld;
        logic       rf_w_en;
        logic       status_w_en;
        logic       rf_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic [1:0] rf_r0_sel;
        logic       alu_in0_sel;
        logic [2:0] alu_in1_sel;
        logic [1:0] alu_sel;
        logic       halted;
        logic       fault;
    } out_t;
    typedef struct {
        out_t  o;
        string name;
    } exp_t;

    logic clk = 0, rst = 1, mem_ack = 0;
    logic [15:0] ir = '0;
    logic [2:0] cond = '0;
    logic mem_req, mem_we, ir_ld, pc_ld, pc_inc, temp_ld, rf_w_en, status_w_en, rf_w_addr_sel;
    logic alu_in0_sel, halted, fault;
    logic [1:0] mem_addr_sel, rf_w_data_sel, rf_r0_sel, alu_sel;
    logic [2:0] alu_in1_sel;
    out_t act, o;
    exp_t q[$];
    exp_t e;
    int total = 0, bad = 0;

    punc_control_hs #(.IR_W(16), .TMO_W(8), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst), .ir(ir), .cond(cond), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_inc(pc_inc), .temp_ld(temp_ld),
        .rf_w_en(rf_w_en), .status_w_en(status_w_en), .rf_w_addr_sel(rf_w_addr_sel),
        .rf_w_data_sel(rf_w_data_sel), .rf_r0_sel(rf_r0_sel), .alu_in0_sel(alu_in0_sel),
        .alu_in1_sel(alu_in1_sel), .alu_sel(alu_sel), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    assign act = {mem_req, mem_we, mem_addr_sel, ir_ld, pc_ld, pc_inc, temp_ld, rf_w_en,
                  status_w_en, rf_w_addr_sel, rf_w_data_sel, rf_r0_sel, alu_in0_sel,
                  alu_in1_sel, alu_sel, halted, fault};

    // Monitor: compare the DUT outputs of every scheduled cycle against the queued expectation
    always @(negedge clk)
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (act !== e.o) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, act, e.o);
            end
        end

    task automatic cyc(input logic ack, input out_t x, input string name);
        mem_ack = ack;
        q.push_back('{o: x, name: name});
        @(posedge clk);
        #1;
    endtask

    function automatic out_t f_fetch(input logic ack);
        out_t r = '0;
        r.mem_req = 1'b1;
        r.ir_ld = ack;
        return r;
    endfunction

    function automatic out_t f_dec();
        out_t r = '0;
        r.pc_inc = 1'b1;
        return r;
    endfunction

    // PC-relative load in MEM: address from ALU = PC + PCOFF9, data from memory
    function automatic out_t f_ld(input logic ack);
        out_t r = '0;
        r.mem_req = 1'b1;
        r.addr = 2'd1;
        r.alu_in0_sel = 1'b1;
        r.alu_in1_sel = 3'd3;
        r.rf_w_data_sel = 2'd1;
        r.rf_w_en = ack;
        r.status_w_en = ack;
        return r;
    endfunction

    task automatic start(input logic [15:0] instr, input string name);
        ir = instr;
        cyc(1'b1, f_fetch(1'b1), {name, "_fetch"});
        cyc(1'b1, f_dec(), {name, "_decode"});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b1, '0, "reset_outputs");
        rst = 0;
        cyc(1'b0, f_fetch(1'b0), "fetch_wait0");
        cyc(1'b0, f_fetch(1'b0), "fetch_wait1");
        // ADD R1,R2,#3 immediate form
        start(16'h12A3, "add_imm");
        o = '0; o.rf_w_en = 1; o.status_w_en = 1; o.alu_in1_sel = 3'd1;
        cyc(1'b0, o, "add_imm_exec");
        // ADD register form (ir[5]=0)
        start(16'h1283, "add_reg");
        o = '0; o.rf_w_en = 1; o.status_w_en = 1;
        cyc(1'b0, o, "add_reg_exec");
        start(16'h5262, "and_imm");
        o = '0; o.rf_w_en = 1; o.status_w_en = 1; o.alu_in1_sel = 3'd1; o.alu_sel = 2'd1;
        cyc(1'b0, o, "and_exec");
        start(16'h927F, "not");
        o = '0; o.rf_w_en = 1; o.status_w_en = 1; o.alu_in1_sel = 3'd1; o.alu_sel = 2'd2;
        cyc(1'b0, o, "not_exec");
        // BRz taken and not taken
        cond = 3'b010;
        start(16'h0405, "brz_t");
        o = '0; o.pc_ld = 1; o.alu_in0_sel = 1; o.alu_in1_sel = 3'd3;
        cyc(1'b0, o, "brz_taken");
        cond = 3'b100;
        start(16'h0405, "brz_nt");
        o = '0; o.alu_in0_sel = 1; o.alu_in1_sel = 3'd3;
        cyc(1'b0, o, "brz_not_taken");
        start(16'h4802, "jsr");
        o = '0; o.pc_ld = 1; o.rf_w_en = 1; o.rf_w_addr_sel = 1; o.rf_w_data_sel = 2'd2;
        o.alu_in0_sel = 1; o.alu_in1_sel = 3'd4;
        cyc(1'b0, o, "jsr_exec");
        start(16'h4080, "jsrr");
        o = '0; o.pc_ld = 1; o.rf_w_en = 1; o.rf_w_addr_sel = 1; o.rf_w_data_sel = 2'd2;
        o.rf_r0_sel = 2'd1; o.alu_sel = 2'd3;
        cyc(1'b0, o, "jsrr_exec");
        start(16'hC080, "jmp");
        o = '0; o.pc_ld = 1; o.rf_r0_sel = 2'd1; o.alu_sel = 2'd3;
        cyc(1'b0, o, "jmp_exec");
        start(16'hE205, "lea");
        o = '0; o.rf_w_en = 1; o.status_w_en = 1; o.alu_in0_sel = 1; o.alu_in1_sel = 3'd3;
        cyc(1'b0, o, "lea_exec");
        start(16'h8000, "nop");
        cyc(1'b0, '0, "nop_exec");
        cyc(1'b0, f_fetch(1'b0), "nop_back_fetch");
        // LD with delayed ack: rf write only on the ack cycle
        start(16'h2205, "ld");
        cyc(1'b0, '0, "ld_exec");
        for (int i = 0; i < LD_WAIT; i++) cyc(1'b0, f_ld(1'b0), "ld_mem_wait");
        cyc(1'b1, f_ld(1'b1), "ld_mem_ack");
        cyc(1'b0, f_fetch(1'b0), "ld_back_fetch");
        // LDR zero-wait access
        start(16'h6283, "ldr");
        cyc(1'b0, '0, "ldr_exec");
        o = '0; o.mem_req = 1; o.addr = 2'd1; o.rf_r0_sel = 2'd1; o.alu_in1_sel = 3'd2;
        o.rf_w_data_sel = 2'd1; o.rf_w_en = 1; o.status_w_en = 1;
        cyc(1'b1, o, "ldr_mem_ack");
        // LDI: pointer fetch (2 waits) then data fetch via TEMP (3 waits)
        start(16'hA205, "ldi");
        cyc(1'b0, '0, "ldi_exec");
        o = '0; o.mem_req = 1; o.addr = 2'd1; o.alu_in0_sel = 1; o.alu_in1_sel = 3'd3;
        cyc(1'b0, o, "ldi_mem_wait0");
        cyc(1'b0, o, "ldi_mem_wait1");
        o.temp_ld = 1;
        cyc(1'b1, o, "ldi_mem_ack");
        o = '0; o.mem_req = 1; o.addr = 2'd2; o.rf_w_data_sel = 2'd1;
        for (int i = 0; i < 3; i++) cyc(1'b0, o, "ldi_memi_wait");
        o.rf_w_en = 1; o.status_w_en = 1;
        cyc(1'b1, o, "ldi_memi_ack");
        cyc(1'b0, f_fetch(1'b0), "ldi_back_fetch");
        // STI zero-wait both phases
        start(16'hB205, "sti");
        cyc(1'b0, '0, "sti_exec");
        o = '0; o.mem_req = 1; o.addr = 2'd1; o.alu_in0_sel = 1; o.alu_in1_sel = 3'd3; o.temp_ld = 1;
        cyc(1'b1, o, "sti_mem_ack");
        o = '0; o.mem_req = 1; o.addr = 2'd2; o.mem_we = 1; o.rf_r0_sel = 2'd2;
        cyc(1'b1, o, "sti_memi_ack");
        start(16'h7283, "str");
        cyc(1'b0, '0, "str_exec");
        o = '0; o.mem_req = 1; o.mem_we = 1; o.addr = 2'd1; o.rf_r0_sel = 2'd2; o.alu_in1_sel = 3'd2;
        cyc(1'b1, o, "str_mem_ack");
        // ST interrupted by reset mid-wait
        start(16'h3205, "st");
        cyc(1'b0, '0, "st_exec");
        o = '0; o.mem_req = 1; o.mem_we = 1; o.addr = 2'd1; o.rf_r0_sel = 2'd2;
        o.alu_in0_sel = 1; o.alu_in1_sel = 3'd3;
        cyc(1'b0, o, "st_mem_wait0");
        cyc(1'b0, o, "st_mem_wait1");
        rst = 1;
        cyc(1'b0, '0, "st_rst_drop_req");
        cyc(1'b1, '0, "st_rst_ack_ignored");
        rst = 0;
        cyc(1'b0, f_fetch(1'b0), "st_after_rst_fetch");
`ifdef PUNC_CTRL_TIMEOUT_EN
        start(16'h2205, "tmo");
        cyc(1'b0, '0, "tmo_exec");
        for (int i = 0; i < 4; i++) cyc(1'b0, f_ld(1'b0), "tmo_mem_wait");
        o = '0; o.fault = 1;
        for (int i = 0; i < 3; i++) cyc(i[0], o, "tmo_fault_hold");
        rst = 1;
        cyc(1'b0, '0, "tmo_rst");
        rst = 0;
        cyc(1'b0, f_fetch(1'b0), "tmo_after_rst_fetch");
`endif
        // HLT: absorbing, stray acks ignored
        start(16'hD000, "hlt");
        cyc(1'b0, '0, "hlt_exec");
        o = '0; o.halted = 1;
        for (int i = 0; i < 100; i++) cyc(i[0], o, "halted_hold");
        rst = 1;
        cyc(1'b0, '0, "hlt_rst");
        rst = 0;
        cyc(1'b0, f_fetch(1'b0), "hlt_after_rst_fetch");
        repeat (2) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
